// File: rtl/out_pcm_pkg.sv
// Shared types and constants for the OUT_PCM channel scheduler.
// FSM encodings are plain 2-bit constants so legacy code can compare against them.
package out_pcm_pkg;

  localparam int SR_W = 16;
  localparam int SE_W = 15;
  localparam int Y_W  = 13;
  localparam int I_W  = 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] EVAL  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  typedef struct packed {
    logic [SR_W-1:0] sr;
    logic [SE_W-1:0] se;
    logic [Y_W-1:0]  y;
    logic [I_W-1:0]  i;
    logic            law;
    logic [1:0]      rate;
  } operands_t;

endpackage

// File: rtl/out_pcm_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module out_pcm_rr_arb #(
  parameter int NCH  = 4,
  parameter int CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [CH_W-1:0] grant_ch,
  output logic            any
);

  int j;

  // Scan from the farthest offset down so the nearest requester is assigned last.
  always_comb begin
    any      = 1'b0;
    grant_ch = '0;
    j        = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (req[j[CH_W-1:0]]) begin
        any      = 1'b1;
        grant_ch = j[CH_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_grant
    assign grant[gi] = any && (grant_ch == CH_W'(gi));
  end

endmodule

// File: rtl/out_pcm_sched.sv
// Shares one OUT_PCM datapath across NCH channels: arbitrate, load operands,
// wait EVAL_CYC cycles for the multicycle path, then hand SD downstream.
module out_pcm_sched
  import out_pcm_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int EVAL_CYC = 2,
  localparam int CH_W    = $clog2(NCH)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [NCH-1:0]  REQ,
  output logic [NCH-1:0]  ACK,
  output logic [CH_W-1:0] ACK_CH,
  input  logic [15:0]     SR_IN,
  input  logic [14:0]     SE_IN,
  input  logic [12:0]     Y_IN,
  input  logic [4:0]      I_IN,
  input  logic            CFG_WE,
  input  logic [CH_W-1:0] CFG_CH,
  input  logic            CFG_LAW,
  input  logic [1:0]      CFG_RATE,
  output logic [15:0]     SR,
  output logic [14:0]     SE,
  output logic [12:0]     Y,
  output logic [4:0]      I,
  output logic            LAW,
  output logic [1:0]      RATE,
  input  logic [7:0]      SD,
  output logic [7:0]      SD_OUT,
  output logic [CH_W-1:0] SD_CH,
  output logic            SD_VALID,
  input  logic            SD_READY
);

  logic [1:0]           state_reg;
  logic [CH_W-1:0]      ptr_reg;
  logic [NCH-1:0]       ack_reg;
  logic [CH_W-1:0]      ack_ch_reg;
  operands_t            op_reg;
  logic [7:0]           sd_out_reg;
  logic [CH_W-1:0]      sd_ch_reg;
  logic                 sd_valid_reg;
  logic [3:0]           cnt_reg;
  logic [NCH-1:0]       cfg_law_reg;
  logic [NCH-1:0][1:0]  cfg_rate_reg;

  logic [NCH-1:0]  busy_mask;
  logic [NCH-1:0]  arb_grant;
  logic [CH_W-1:0] arb_ch;
  logic            arb_any;
  logic            grant_fire;

  // The channel whose word sits in OUT must not be reissued on its own accept edge.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_busy
    assign busy_mask[gi] = (state_reg == OUT) && (ack_ch_reg == CH_W'(gi));
  end

  out_pcm_rr_arb #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .req      (REQ & ~busy_mask),
    .ptr      (ptr_reg),
    .grant    (arb_grant),
    .grant_ch (arb_ch),
    .any      (arb_any)
  );

  assign grant_fire = arb_any && ((state_reg == IDLE) || ((state_reg == OUT) && SD_READY));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      ack_reg      <= '0;
      ack_ch_reg   <= '0;
      op_reg       <= '0;
      sd_out_reg   <= '0;
      sd_ch_reg    <= '0;
      sd_valid_reg <= 1'b0;
      cnt_reg      <= '0;
      cfg_law_reg  <= '0;
      cfg_rate_reg <= '0;
    end else begin
      ack_reg <= '0;
      for (int k = 0; k < NCH; k++) begin
        if (CFG_WE && (CFG_CH == CH_W'(k))) begin
          cfg_law_reg[k]  <= CFG_LAW;
          cfg_rate_reg[k] <= CFG_RATE;
        end
      end
      case (state_reg)
        GRANT: begin
          op_reg    <= '{sr: SR_IN, se: SE_IN, y: Y_IN, i: I_IN,
                         law: cfg_law_reg[ack_ch_reg], rate: cfg_rate_reg[ack_ch_reg]};
          cnt_reg   <= '0;
          state_reg <= EVAL;
        end
        EVAL: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg + 4'd1 == 4'(EVAL_CYC)) begin
            sd_out_reg   <= SD;
            sd_ch_reg    <= ack_ch_reg;
            sd_valid_reg <= 1'b1;
            state_reg    <= OUT;
          end
        end
        OUT: begin
          if (SD_READY) begin
            sd_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: ;
      endcase
      // Going straight from OUT to GRANT avoids an idle bubble between words.
      if (grant_fire) begin
        state_reg  <= GRANT;
        ack_reg    <= arb_grant;
        ack_ch_reg <= arb_ch;
        ptr_reg    <= (arb_ch == CH_W'(NCH - 1)) ? '0 : arb_ch + CH_W'(1);
      end
    end
  end

  assign ACK      = ack_reg;
  assign ACK_CH   = ack_ch_reg;
  assign SR       = op_reg.sr;
  assign SE       = op_reg.se;
  assign Y        = op_reg.y;
  assign I        = op_reg.i;
  assign LAW      = op_reg.law;
  assign RATE     = op_reg.rate;
  assign SD_OUT   = sd_out_reg;
  assign SD_CH    = sd_ch_reg;
  assign SD_VALID = sd_valid_reg;

endmodule
